shift_arbiter24: RTL

- Time-multiplexes one shared shifter24 instance between NUM_CHAN channels of 50-bit accumulator results.
- Captures per-channel samples and grants the shifter round-robin, one channel per cycle.
- Drives the shifter's input and shift amount, then registers the 24-bit clipped, rounded result with a channel tag.
- Sits between the decimator/integrator accumulators and the RX packing logic.

---
 rtl/shift_arb_pkg.sv | 27 ++
 rtl/shift_arbiter24_rr_arbiter.sv | 31 +++
 rtl/shift_arbiter24.sv | 128 ++++++++++++
 3 files changed

// File: rtl/shift_arb_pkg.sv
// Shared constants and helpers for the shift_arbiter24 time-multiplexed shifter controller.
// Widths follow the accumulator (50 b), packed result (24 b) and shift-amount (8 b) buses.

package shift_arb_pkg;

  localparam int IN_W      = 50;
  localparam int OUT_W     = 24;
  localparam int SHIFT_W   = 8;
  localparam int SHIFT_MAX = 22;
  localparam int CNT_W     = 16;

  localparam logic [OUT_W-1:0] POS_FS = 24'h7FFFFF;
  localparam logic [OUT_W-1:0] NEG_FS = 24'h800000;

  // The shifter silently maps out-of-range shifts to 0, so the controller
  // limits requests to the largest shift that still means something.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    logic [SHIFT_W-1:0] lim;
    lim = SHIFT_W'(SHIFT_MAX);
    return (s > lim) ? lim : s;
  endfunction

  function automatic logic is_full_scale(input logic [OUT_W-1:0] v);
    return (v == POS_FS) || (v == NEG_FS);
  endfunction

endpackage

// File: rtl/shift_arbiter24_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at N-1.
// Requests are scanned from the far end back towards ptr so the nearest one wins.

module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/shift_arbiter24.sv
// Shares one external shifter24 between NUM_CHAN accumulator channels, round-robin, one grant per cycle.
// Optional per-channel full-scale (clip) counters are built when SHIFT_ARB_CLIP_STATS_EN is defined.

module shift_arbiter24
  import shift_arb_pkg::*;
#(
  parameter int NUM_CHAN = 4,
  parameter int CHAN_W   = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_CHAN-1:0]         in_strobe,
  input  logic [NUM_CHAN*IN_W-1:0]    in_data,
  input  logic [NUM_CHAN*SHIFT_W-1:0] shift_cfg,
  output logic [IN_W-1:0]             sh_in,
  output logic [SHIFT_W-1:0]          sh_shift,
  input  logic [OUT_W-1:0]            sh_out,
  output logic [OUT_W-1:0]            out_data,
  output logic [CHAN_W-1:0]           out_chan,
  output logic                        out_strobe,
  output logic [NUM_CHAN-1:0]         overrun,
`ifdef SHIFT_ARB_CLIP_STATS_EN
  input  logic [CHAN_W-1:0]           clip_sel,
  input  logic                        clip_clr,
  output logic [CNT_W-1:0]            clip_count,
`endif
  input  logic [NUM_CHAN-1:0]         overrun_clr
);

  logic [IN_W-1:0]     hold       [NUM_CHAN];
  logic [SHIFT_W-1:0]  shift_hold [NUM_CHAN];

  logic [NUM_CHAN-1:0] pending;
  logic [NUM_CHAN-1:0] pending_nxt;
  logic [NUM_CHAN-1:0] capture;
  logic [NUM_CHAN-1:0] granted_oh;
  logic [NUM_CHAN-1:0] overrun_nxt;

  logic [CHAN_W-1:0]   ptr;
  logic [CHAN_W-1:0]   ptr_inc;
  logic [CHAN_W-1:0]   gnt_idx;
  logic [CHAN_W-1:0]   sel;
  logic                gnt_valid;
  logic                grant;

  rr_arbiter #(
    .N (NUM_CHAN),
    .W (CHAN_W)
  ) u_rr_arbiter (
    .req       (pending),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign grant = enable & gnt_valid;

  // With nothing granted the shifter still sees a defined channel (the pointer).
  assign sel      = gnt_valid ? gnt_idx : ptr;
  assign sh_in    = hold[sel];
  assign sh_shift = shift_hold[sel];

  assign ptr_inc = (gnt_idx == CHAN_W'(NUM_CHAN - 1)) ? '0 : gnt_idx + CHAN_W'(1);

  // A channel granted this cycle frees its slot at the same edge, so a fresh
  // strobe there is a legal capture rather than an overrun.
  always_comb begin
    granted_oh  = '0;
    capture     = '0;
    pending_nxt = '0;
    overrun_nxt = '0;
    if (grant) granted_oh[gnt_idx] = 1'b1;
    for (int c = 0; c < NUM_CHAN; c++) begin
      capture[c]     = enable & in_strobe[c] & (~pending[c] | granted_oh[c]);
      pending_nxt[c] = enable & (capture[c] | (pending[c] & ~granted_oh[c]));
      overrun_nxt[c] = (enable & in_strobe[c] & pending[c] & ~granted_oh[c])
                     | (overrun[c] & ~overrun_clr[c]);
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      pending    <= '0;
      overrun    <= '0;
      ptr        <= '0;
      out_strobe <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
    end else begin
      pending    <= pending_nxt;
      overrun    <= overrun_nxt;
      out_strobe <= grant;
      if (grant) begin
        out_data <= sh_out;
        out_chan <= gnt_idx;
        ptr      <= ptr_inc;
      end
    end
  end

  // NOTE: sample holding registers are not reset; they are only read while pending is set.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (capture[c]) begin
        hold[c]       <= in_data[c*IN_W +: IN_W];
        shift_hold[c] <= clamp_shift(shift_cfg[c*SHIFT_W +: SHIFT_W]);
      end
    end
  end

`ifdef SHIFT_ARB_CLIP_STATS_EN
  logic [CNT_W-1:0] clip_cnt [NUM_CHAN];

  // Counts full-scale codes on the edge they are registered into out_data; clear beats increment.
  always_ff @(posedge clock) begin
    if (reset || clip_clr) begin
      for (int c = 0; c < NUM_CHAN; c++) clip_cnt[c] <= '0;
    end else if (grant && is_full_scale(sh_out) && (clip_cnt[gnt_idx] != {CNT_W{1'b1}})) begin
      clip_cnt[gnt_idx] <= clip_cnt[gnt_idx] + CNT_W'(1);
    end
  end

  assign clip_count = clip_cnt[clip_sel];
`endif

endmodule
